execute_stage: RTL and testbench
================================

// Module: execute_stage
// PURPOSE
//  RV32I execute stage: registered pipeline slot between decode and mem_stage.
//  Computes ALU results, effective addresses and link values.
//  Resolves branches and jumps, then issues a one-cycle PC redirect and upstream flush.
//  Follows the pipeline ce/stall/flush handshake. Outputs feed mem_stage me_i_* directly.
// PARAMETERS
//  DWIDTH    32  data / PC width
//  AWIDTH    5   register-file address width
// PORTS
//  me_clk         in   1       clock; all state updates on rising edge
//  me_rst         in   1       asynchronous, active-low reset
//  ex_i_ce        in   1       valid instruction presented by decode
//  ex_i_stall     in   1       downstream stall (mem_stage me_o_stall)
//  ex_i_flush     in   1       external flush (trap / older redirect)
//  ex_o_stall     out  1       decode must hold its instruction
//  ex_o_flush     out  1       kill wrong-path instructions upstream
//  ex_o_ce        out  1       one-cycle valid pulse to mem_stage
//  ex_i_opcode    in   7       `OPCODE_WIDTH opcode
//  ex_i_funct3    in   3       funct3
//  ex_i_funct7_5  in   1       instr[30]; selects SUB / SRA / SRAI
//  ex_i_pc        in   DWIDTH  instruction PC
//  ex_i_rs1_data  in   DWIDTH  operand rs1 (already forwarded)
//  ex_i_rs2_data  in   DWIDTH  operand rs2 (already forwarded)
//  ex_i_imm       in   DWIDTH  sign-extended immediate
//  ex_i_rd_addr   in   AWIDTH  destination register
//  ex_o_opcode / ex_o_funct3  out  7 / 3   registered copies
//  ex_o_alu_value out  DWIDTH  result, address or link value
//  ex_o_rs2_data  out  DWIDTH  store data, unaligned
//  ex_o_rd_addr   out  AWIDTH  destination; 0 for STORE / BRANCH
//  ex_o_change_pc out  1       one-cycle redirect strobe to fetch
//  ex_o_next_pc   out  DWIDTH  redirect target; valid while change_pc=1
// BEHAVIOUR
//  Reset: every output and internal flag is 0.
//  Accept: accept = ex_i_ce & ~ex_i_stall & ~ex_i_flush & ~shadow.
//   - Registers load only on accept. ex_o_ce <= accept. Latency is 1 cycle.
//  ex_o_stall = ex_i_stall (combinational). Decode holds; nothing is dropped.
//  Stall: all data outputs hold. ex_o_ce = 0 while stalled.
//   - Each instruction produces exactly one ex_o_ce pulse.
//  Results:
//   - RTYPE / ITYPE: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
//   - Shift amount is operand_b[4:0].
//   - ITYPE ignores funct7_5 except funct3=101 (SRAI).
//   - LOAD / STORE: rs1 + imm.   LUI: imm.   AUIPC: pc + imm.
//   - JAL / JALR: pc + 4.        BRANCH: 0.
//   - All adds are mod 2^DWIDTH.
//  Branch compare:
//   - BEQ 000, BNE 001, BLT 100, BGE 101: signed.
//   - BLTU 110, BGEU 111: unsigned.
//  Targets:
//   - Taken branch and JAL: pc + imm.
//   - JALR: (rs1 + imm) & ~1.
//  Redirect: accepting a taken branch / JAL / JALR in cycle N gives, in cycle N+1:
//   - ex_o_change_pc = 1, ex_o_next_pc = target, ex_o_flush = 1, for one cycle.
//   - The shadow flag is set for cycle N+1: the wrong-path instruction presented then is not accepted.
//   - Not-taken branch: no redirect.
//  Flush: ex_i_flush = 1 gives next edge ex_o_ce = 0, ex_o_flush = 1, ex_o_change_pc = 0, shadow = 0.
//   - Flush has priority over accept, stall and redirect. ex_o_flush otherwise returns to 0.
//  Simultaneous: a redirect strobe always completes, even if ex_i_stall rises in cycle N+1.
//   - Stall plus flush: the flush wins.
//  Reset mid-operation: immediately returns all state to reset values. No pending redirect survives.
// STRUCTURE
//  Shared header.vh:
//   - Opcode macros (`RTYPE, `ITYPE, `LOAD, `STORE, `BRANCH, `JAL, `JALR, `LUI, `AUIPC).
//   - New `FUNCT_BEQ..`FUNCT_BGEU and ALU-op encodings.
//  One combinational sub-module ex_alu (op, a, b -> result).
//  Operand select, branch compare, pipeline register and redirect/shadow FSM stay in execute_stage.
// TESTING
//  1. ADDI x5, rs1=0xFFFFFFFF, imm=1, ce=1
//     -> next cycle alu_value = 0, rd_addr = 5, ce pulse of 1 cycle.
//  2. SRA rs1=0x80000010, rs2=4, funct7_5=1 -> 0xF8000001.
//     Same with funct7_5=0 (SRL) -> 0x08000001.
//  3. BLT pc=0x100, rs1=-1, rs2=1, imm=0x20
//     -> change_pc = 1, next_pc = 0x120, flush = 1 for one cycle; the following input is not accepted.
//     BLTU with the same operands -> no redirect.
//  4. JALR pc=0x40, rs1=0x1003, imm=4
//     -> alu_value = 0x44, next_pc = 0x1006.
//  5. ex_i_stall=1 for 3 cycles while ce=1
//     -> outputs stable, ex_o_ce = 0, ex_o_stall = 1.
//     After release: exactly one ce pulse carrying the held instruction.
//  6. ex_i_flush with a taken JAL in the same cycle
//     -> no change_pc, ex_o_flush = 1, ex_o_ce = 0.
//     me_rst low mid-redirect -> all outputs 0.

Source files
------------

// File: rtl/execute_stage_pkg.sv
// Shared RV32I execute-stage definitions: opcodes, branch funct3 codes, ALU op encoding.
`default_nettype none

package execute_stage_pkg;

    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [2:0] FUNCT_BEQ  = 3'b000;
    localparam logic [2:0] FUNCT_BNE  = 3'b001;
    localparam logic [2:0] FUNCT_BLT  = 3'b100;
    localparam logic [2:0] FUNCT_BGE  = 3'b101;
    localparam logic [2:0] FUNCT_BLTU = 3'b110;
    localparam logic [2:0] FUNCT_BGEU = 3'b111;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

    // alt_i selects SUB for funct3=000 and SRA for funct3=101
    function automatic alu_op_e alu_op_decode(input logic [2:0] funct3_i, input logic alt_i);
        case (funct3_i)
            3'b000:  return alt_i ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt_i ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/ex_alu.sv
// Combinational RV32I integer ALU.
`default_nettype none

module ex_alu
    import execute_stage_pkg::*;
#(
    parameter int DWIDTH = 32
) (
    input  alu_op_e           op_i,
    input  logic [DWIDTH-1:0] a_i,
    input  logic [DWIDTH-1:0] b_i,
    output logic [DWIDTH-1:0] result_o
);

    logic [4:0] w_shamt;
    assign w_shamt = b_i[4:0];

    always_comb begin
        result_o = '0;
        case (op_i)
            ALU_ADD:  result_o = a_i + b_i;
            ALU_SUB:  result_o = a_i - b_i;
            ALU_SLL:  result_o = a_i << w_shamt;
            ALU_SLT:  result_o = {{(DWIDTH-1){1'b0}}, $signed(a_i) < $signed(b_i)};
            ALU_SLTU: result_o = {{(DWIDTH-1){1'b0}}, a_i < b_i};
            ALU_XOR:  result_o = a_i ^ b_i;
            ALU_SRL:  result_o = a_i >> w_shamt;
            ALU_SRA:  result_o = $unsigned($signed(a_i) >>> w_shamt);
            ALU_OR:   result_o = a_i | b_i;
            ALU_AND:  result_o = a_i & b_i;
            default:  result_o = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/execute_stage.sv
// RV32I execute stage: operand select, branch resolution, pipeline register and redirect/shadow control.
`default_nettype none

module execute_stage
    import execute_stage_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 5
) (
    input  logic              me_clk,
    input  logic              me_rst,
    input  logic              ex_i_ce,
    input  logic              ex_i_stall,
    input  logic              ex_i_flush,
    output logic              ex_o_stall,
    output logic              ex_o_flush,
    output logic              ex_o_ce,
    input  logic [6:0]        ex_i_opcode,
    input  logic [2:0]        ex_i_funct3,
    input  logic              ex_i_funct7_5,
    input  logic [DWIDTH-1:0] ex_i_pc,
    input  logic [DWIDTH-1:0] ex_i_rs1_data,
    input  logic [DWIDTH-1:0] ex_i_rs2_data,
    input  logic [DWIDTH-1:0] ex_i_imm,
    input  logic [AWIDTH-1:0] ex_i_rd_addr,
    output logic [6:0]        ex_o_opcode,
    output logic [2:0]        ex_o_funct3,
    output logic [DWIDTH-1:0] ex_o_alu_value,
    output logic [DWIDTH-1:0] ex_o_rs2_data,
    output logic [AWIDTH-1:0] ex_o_rd_addr,
    output logic              ex_o_change_pc,
    output logic [DWIDTH-1:0] ex_o_next_pc
);

    logic              ce_q, ce_d, flush_q, flush_d, change_pc_q, change_pc_d, shadow_q, shadow_d;
    logic [6:0]        opcode_q, opcode_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [DWIDTH-1:0] alu_q, alu_d, rs2_q, rs2_d, next_pc_q, next_pc_d;
    logic [AWIDTH-1:0] rd_q, rd_d;

    logic              w_accept, w_taken, w_redirect;
    logic [DWIDTH-1:0] w_a, w_b, w_result, w_target, w_pc_imm, w_jalr_sum;
    logic [AWIDTH-1:0] w_rd;
    alu_op_e           w_op;

    assign w_accept   = ex_i_ce & ~ex_i_stall & ~ex_i_flush & ~shadow_q;
    assign w_pc_imm   = ex_i_pc + ex_i_imm;
    assign w_jalr_sum = ex_i_rs1_data + ex_i_imm;
    assign w_rd       = (ex_i_opcode == OPC_STORE || ex_i_opcode == OPC_BRANCH) ? '0 : ex_i_rd_addr;

    always_comb begin
        w_taken = 1'b0;
        case (ex_i_funct3)
            FUNCT_BEQ:  w_taken = (ex_i_rs1_data == ex_i_rs2_data);
            FUNCT_BNE:  w_taken = (ex_i_rs1_data != ex_i_rs2_data);
            FUNCT_BLT:  w_taken = ($signed(ex_i_rs1_data) <  $signed(ex_i_rs2_data));
            FUNCT_BGE:  w_taken = ($signed(ex_i_rs1_data) >= $signed(ex_i_rs2_data));
            FUNCT_BLTU: w_taken = (ex_i_rs1_data <  ex_i_rs2_data);
            FUNCT_BGEU: w_taken = (ex_i_rs1_data >= ex_i_rs2_data);
            default:    w_taken = 1'b0;
        endcase
    end

    // Operand select: every result is expressed as an ALU operation on (a, b)
    always_comb begin
        w_a        = ex_i_rs1_data;
        w_b        = ex_i_imm;
        w_op       = ALU_ADD;
        w_redirect = 1'b0;
        w_target   = w_pc_imm;
        case (ex_i_opcode)
            OPC_RTYPE: begin
                w_b  = ex_i_rs2_data;
                w_op = alu_op_decode(ex_i_funct3, ex_i_funct7_5);
            end
            OPC_ITYPE:  w_op = alu_op_decode(ex_i_funct3, ex_i_funct7_5 & (ex_i_funct3 == 3'b101));
            OPC_LOAD, OPC_STORE: ;
            OPC_LUI:    w_a = '0;
            OPC_AUIPC:  w_a = ex_i_pc;
            OPC_JAL: begin
                w_a        = ex_i_pc;
                w_b        = DWIDTH'(4);
                w_redirect = 1'b1;
            end
            OPC_JALR: begin
                w_a        = ex_i_pc;
                w_b        = DWIDTH'(4);
                w_redirect = 1'b1;
                w_target   = {w_jalr_sum[DWIDTH-1:1], 1'b0};
            end
            OPC_BRANCH: begin
                w_a        = '0;
                w_b        = '0;
                w_redirect = w_taken;
            end
            default: begin
                w_a = '0;
                w_b = '0;
            end
        endcase
    end

    ex_alu #(.DWIDTH(DWIDTH)) u_alu (
        .op_i     (w_op),
        .a_i      (w_a),
        .b_i      (w_b),
        .result_o (w_result)
    );

    // Strobes default low; data registers hold unless a new instruction is accepted
    always_comb begin
        ce_d        = 1'b0;
        flush_d     = 1'b0;
        change_pc_d = 1'b0;
        shadow_d    = 1'b0;
        opcode_d    = opcode_q;
        funct3_d    = funct3_q;
        alu_d       = alu_q;
        rs2_d       = rs2_q;
        rd_d        = rd_q;
        next_pc_d   = next_pc_q;
        if (ex_i_flush) begin
            flush_d = 1'b1;
        end else if (w_accept) begin
            ce_d     = 1'b1;
            opcode_d = ex_i_opcode;
            funct3_d = ex_i_funct3;
            alu_d    = w_result;
            rs2_d    = ex_i_rs2_data;
            rd_d     = w_rd;
            if (w_redirect) begin
                change_pc_d = 1'b1;
                flush_d     = 1'b1;
                shadow_d    = 1'b1;
                next_pc_d   = w_target;
            end
        end
    end

    always_ff @(posedge me_clk or negedge me_rst) begin
        if (!me_rst) begin
            ce_q        <= 1'b0;
            flush_q     <= 1'b0;
            change_pc_q <= 1'b0;
            shadow_q    <= 1'b0;
            opcode_q    <= '0;
            funct3_q    <= '0;
            alu_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            next_pc_q   <= '0;
        end else begin
            ce_q        <= ce_d;
            flush_q     <= flush_d;
            change_pc_q <= change_pc_d;
            shadow_q    <= shadow_d;
            opcode_q    <= opcode_d;
            funct3_q    <= funct3_d;
            alu_q       <= alu_d;
            rs2_q       <= rs2_d;
            rd_q        <= rd_d;
            next_pc_q   <= next_pc_d;
        end
    end

    assign ex_o_stall     = ex_i_stall;
    assign ex_o_flush     = flush_q;
    assign ex_o_ce        = ce_q;
    assign ex_o_opcode    = opcode_q;
    assign ex_o_funct3    = funct3_q;
    assign ex_o_alu_value = alu_q;
    assign ex_o_rs2_data  = rs2_q;
    assign ex_o_rd_addr   = rd_q;
    assign ex_o_change_pc = change_pc_q;
    assign ex_o_next_pc   = next_pc_q;

endmodule

`default_nettype wire

// File: tb/tb_execute_stage.sv
// Testbench for execute_stage: directed cases plus randomized traffic against a reference model.
`default_nettype none

module tb_execute_stage;

    localparam logic [6:0] RT = 7'b0110011, IT = 7'b0010011, LD = 7'b0000011, ST = 7'b0100011,
                           BR = 7'b1100011, JL = 7'b1101111, JR = 7'b1100111, LU = 7'b0110111,
                           AU = 7'b0010111;

    logic        me_clk = 1'b0;
    logic        me_rst;
    logic        ce, stall, flush, f7;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] pc, rs1, rs2, imm;
    logic [4:0]  rd;

    logic        o_stall, o_flush, o_ce, o_cpc;
    logic [6:0]  o_opcode;
    logic [2:0]  o_funct3;
    logic [31:0] o_alu, o_rs2, o_npc;
    logic [4:0]  o_rd;

    // reference-model view of the registered outputs
    logic        m_ce, m_flush, m_cpc, m_shadow;
    logic [6:0]  m_opcode;
    logic [2:0]  m_funct3;
    logic [31:0] m_alu, m_rs2, m_npc;
    logic [4:0]  m_rd;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 me_clk = ~me_clk;

    execute_stage #(.DWIDTH(32), .AWIDTH(5)) dut (
        .me_clk         (me_clk),
        .me_rst         (me_rst),
        .ex_i_ce        (ce),
        .ex_i_stall     (stall),
        .ex_i_flush     (flush),
        .ex_o_stall     (o_stall),
        .ex_o_flush     (o_flush),
        .ex_o_ce        (o_ce),
        .ex_i_opcode    (opcode),
        .ex_i_funct3    (funct3),
        .ex_i_funct7_5  (f7),
        .ex_i_pc        (pc),
        .ex_i_rs1_data  (rs1),
        .ex_i_rs2_data  (rs2),
        .ex_i_imm       (imm),
        .ex_i_rd_addr   (rd),
        .ex_o_opcode    (o_opcode),
        .ex_o_funct3    (o_funct3),
        .ex_o_alu_value (o_alu),
        .ex_o_rs2_data  (o_rs2),
        .ex_o_rd_addr   (o_rd),
        .ex_o_change_pc (o_cpc),
        .ex_o_next_pc   (o_npc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Architectural meaning of one instruction: result, destination, redirect and target
    task automatic ref_exec(output logic [31:0] val, output logic [4:0] dst,
                            output bit redir, output logic [31:0] tgt);
        logic [31:0] b;
        val   = 32'd0;
        dst   = rd;
        redir = 1'b0;
        tgt   = pc + imm;
        case (opcode)
            RT, IT: begin
                b = (opcode == RT) ? rs2 : imm;
                case (funct3)
                    3'd0: val = (opcode == RT && f7) ? rs1 - b : rs1 + b;
                    3'd1: val = rs1 << b[4:0];
                    3'd2: val = ($signed(rs1) < $signed(b)) ? 32'd1 : 32'd0;
                    3'd3: val = (rs1 < b) ? 32'd1 : 32'd0;
                    3'd4: val = rs1 ^ b;
                    3'd5: val = f7 ? $unsigned($signed(rs1) >>> b[4:0]) : rs1 >> b[4:0];
                    3'd6: val = rs1 | b;
                    default: val = rs1 & b;
                endcase
            end
            LD: val = rs1 + imm;
            ST: begin val = rs1 + imm; dst = 5'd0; end
            LU: val = imm;
            AU: val = pc + imm;
            JL: begin val = pc + 32'd4; redir = 1'b1; end
            JR: begin val = pc + 32'd4; redir = 1'b1; tgt = (rs1 + imm) & 32'hFFFF_FFFE; end
            BR: begin
                dst = 5'd0;
                case (funct3)
                    3'd0: redir = (rs1 == rs2);
                    3'd1: redir = (rs1 != rs2);
                    3'd4: redir = $signed(rs1) <  $signed(rs2);
                    3'd5: redir = $signed(rs1) >= $signed(rs2);
                    3'd6: redir = rs1 <  rs2;
                    3'd7: redir = rs1 >= rs2;
                    default: redir = 1'b0;
                endcase
            end
            default: val = 32'd0;
        endcase
    endtask

    task automatic model_reset();
        {m_ce, m_flush, m_cpc, m_shadow} = 4'b0;
        m_opcode = '0; m_funct3 = '0; m_alu = '0; m_rs2 = '0; m_npc = '0; m_rd = '0;
    endtask

    task automatic check_all();
        chk("ce", {31'd0, o_ce}, {31'd0, m_ce});
        chk("flush_o", {31'd0, o_flush}, {31'd0, m_flush});
        chk("change_pc", {31'd0, o_cpc}, {31'd0, m_cpc});
        chk("alu_value", o_alu, m_alu);
        chk("rd_addr", {27'd0, o_rd}, {27'd0, m_rd});
        chk("opcode_o", {25'd0, o_opcode}, {25'd0, m_opcode});
        chk("funct3_o", {29'd0, o_funct3}, {29'd0, m_funct3});
        chk("rs2_o", o_rs2, m_rs2);
        if (m_cpc) chk("next_pc", o_npc, m_npc);
    endtask

    // Called just after a falling edge with inputs set; advances one clock and checks.
    task automatic cycle();
        logic [31:0] v, t;
        logic [4:0]  d;
        bit          r, acc;
        #1;
        chk("stall_o", {31'd0, o_stall}, {31'd0, stall});
        ref_exec(v, d, r, t);
        acc = ce && !stall && !flush && !m_shadow;
        m_ce = 1'b0; m_cpc = 1'b0; m_flush = flush; m_shadow = 1'b0;
        if (acc) begin
            m_ce = 1'b1;
            m_opcode = opcode; m_funct3 = funct3; m_alu = v; m_rs2 = rs2; m_rd = d;
            if (r) begin
                m_cpc = 1'b1; m_flush = 1'b1; m_shadow = 1'b1; m_npc = t;
            end
        end
        @(posedge me_clk);
        @(negedge me_clk);
        check_all();
    endtask

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic alt,
                             input logic [31:0] p, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] i, input logic [4:0] dst);
        opcode = op; funct3 = f3; f7 = alt; pc = p; rs1 = a; rs2 = b; imm = i; rd = dst;
    endtask

    task automatic rand_instr();
        logic [6:0] ops [9];
        ops = '{RT, IT, LD, ST, BR, JL, JR, LU, AU};
        opcode = ops[$urandom_range(0, 8)];
        funct3 = 3'($urandom);
        if (opcode == BR && funct3[2:1] == 2'b01) funct3[2] = 1'b1;
        f7  = 1'($urandom);
        pc  = $urandom & 32'hFFFF_FFFC;
        rs1 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 8)) - 32'd4 : $urandom;
        rs2 = ($urandom_range(0, 3) == 0) ? rs1 : $urandom;
        imm = ($urandom_range(0, 1) == 0) ? 32'($signed($urandom_range(0, 4095)) - 2048) : $urandom;
        rd  = 5'($urandom);
    endtask

    initial begin
        me_rst = 1'b0;
        {ce, stall, flush} = 3'b0;
        set_instr(7'd0, 3'd0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0);
        model_reset();
        repeat (3) @(negedge me_clk);
        me_rst = 1'b1;
        check_all();

        // ADDI wraps to zero
        set_instr(IT, 3'd0, 1'b0, 32'h10, 32'hFFFF_FFFF, 32'd0, 32'd1, 5'd5);
        ce = 1'b1; cycle();
        chk("addi_val", o_alu, 32'd0);
        chk("addi_rd", {27'd0, o_rd}, 32'd5);
        ce = 1'b0; cycle();
        chk("addi_pulse", {31'd0, o_ce}, 32'd0);

        // SRA / SRL
        set_instr(RT, 3'd5, 1'b1, 32'h20, 32'h8000_0010, 32'd4, 32'd0, 5'd7);
        ce = 1'b1; cycle();
        chk("sra", o_alu, 32'hF800_0001);
        f7 = 1'b0; cycle();
        chk("srl", o_alu, 32'h0800_0001);

        // Taken BLT, shadowed follower, then not-taken BLTU
        set_instr(BR, 3'd4, 1'b0, 32'h100, 32'hFFFF_FFFF, 32'd1, 32'h20, 5'd3);
        cycle();
        chk("blt_cpc", {31'd0, o_cpc}, 32'd1);
        chk("blt_npc", o_npc, 32'h120);
        chk("blt_flush", {31'd0, o_flush}, 32'd1);
        set_instr(IT, 3'd0, 1'b0, 32'h104, 32'd9, 32'd0, 32'd1, 5'd2);
        cycle();
        chk("shadow_ce", {31'd0, o_ce}, 32'd0);
        chk("shadow_cpc", {31'd0, o_cpc}, 32'd0);
        set_instr(BR, 3'd6, 1'b0, 32'h100, 32'hFFFF_FFFF, 32'd1, 32'h20, 5'd3);
        cycle();
        chk("bltu_cpc", {31'd0, o_cpc}, 32'd0);
        chk("bltu_ce", {31'd0, o_ce}, 32'd1);

        // JALR link and target
        set_instr(JR, 3'd0, 1'b0, 32'h40, 32'h1003, 32'd0, 32'd4, 5'd1);
        cycle();
        chk("jalr_link", o_alu, 32'h44);
        chk("jalr_tgt", o_npc, 32'h1006);
        ce = 1'b0; cycle();

        // Stall for three cycles, then one pulse
        set_instr(RT, 3'd0, 1'b1, 32'h80, 32'd50, 32'd8, 32'd0, 5'd9);
        ce = 1'b1; stall = 1'b1;
        repeat (3) begin
            cycle();
            chk("stall_ce", {31'd0, o_ce}, 32'd0);
        end
        stall = 1'b0; cycle();
        chk("unstall_val", o_alu, 32'd42);
        ce = 1'b0; cycle();
        chk("single_pulse", {31'd0, o_ce}, 32'd0);

        // Flush beats a taken JAL
        set_instr(JL, 3'd0, 1'b0, 32'h200, 32'd0, 32'd0, 32'h40, 5'd1);
        ce = 1'b1; flush = 1'b1; cycle();
        chk("flush_cpc", {31'd0, o_cpc}, 32'd0);
        chk("flush_out", {31'd0, o_flush}, 32'd1);
        flush = 1'b0; ce = 1'b0; cycle();

        // Asynchronous reset while a redirect is showing
        ce = 1'b1; cycle();
        chk("jal_cpc", {31'd0, o_cpc}, 32'd1);
        #2 me_rst = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("rst_npc", o_npc, 32'd0);
        @(negedge me_clk);
        me_rst = 1'b1;
        set_instr(IT, 3'd0, 1'b0, 32'h0, 32'd3, 32'd0, 32'd4, 5'd6);
        cycle();
        chk("post_rst_ce", {31'd0, o_ce}, 32'd1);

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            rand_instr();
            ce    = ($urandom_range(0, 9) < 7);
            stall = ($urandom_range(0, 9) < 2);
            flush = ($urandom_range(0, 19) == 0);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
